// File: rtl/riio_bias_ctrl.sv
// Power-up sequencer and health supervisor for the EG1D80V bandgap/bias cell.
// Optional macro BIAS_CTRL_AUTO_RETRY_EN: retry SETTLE timeouts up to 3 times before FAULT.
//
// state   | meaning
// IDLE    | cell off, trims follow config, wait for a request
// STARTUP | startup pulse high, counting STARTUP_CYC cycles
// SETTLE  | waiting up to SETTLE_CYC cycles for synchronised valid
// ON      | bias up, enables and trims follow the core
// FAULT   | timeout or valid lost, held until CLR_FAULT_I
module riio_bias_ctrl #(
    parameter int STARTUP_CYC = 64,
    parameter int SETTLE_CYC  = 1024
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       REQ_IBIAS_I,
    input  logic       REQ_VBIAS_I,
    input  logic [4:0] TRIM_IBIAS_CFG_I,
    input  logic [3:0] TRIM_VBIAS_CFG_I,
    input  logic       CLR_FAULT_I,
    input  logic       BG_VALID_I,
    output logic       EN_IBIAS_O,
    output logic       EN_VBIAS_O,
    output logic       BG_STARTUP_O,
    output logic [4:0] TRIM_IBIAS_O,
    output logic [3:0] TRIM_VBIAS_O,
    output logic       READY_O,
    output logic       FAULT_O,
    output logic [2:0] STATE_O
);

    localparam int MAX_CYC = (STARTUP_CYC > SETTLE_CYC) ? STARTUP_CYC : SETTLE_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] STARTUP_LOAD = CNT_W'(STARTUP_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        STARTUP = 3'd1,
        SETTLE  = 3'd2,
        ON      = 3'd3,
        FAULT   = 3'd4
    } state_t;

    state_t           state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic             vsyncMeta, vsync;
    logic             reqAny;
    logic             enIbiasNext, enVbiasNext, startupNext, readyNext, faultNext;
    logic [4:0]       trimIbiasNext;
    logic [3:0]       trimVbiasNext;
`ifdef BIAS_CTRL_AUTO_RETRY_EN
    logic [1:0]       retryCnt, retryNext;
`endif

    assign reqAny  = REQ_IBIAS_I | REQ_VBIAS_I;
    assign STATE_O = state;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            vsyncMeta <= 1'b0;
            vsync     <= 1'b0;
        end else begin
            vsyncMeta <= BG_VALID_I;
            vsync     <= vsyncMeta;
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state        <= IDLE;
            cnt          <= '0;
            EN_IBIAS_O   <= 1'b0;
            EN_VBIAS_O   <= 1'b0;
            BG_STARTUP_O <= 1'b0;
            TRIM_IBIAS_O <= '0;
            TRIM_VBIAS_O <= '0;
            READY_O      <= 1'b0;
            FAULT_O      <= 1'b0;
`ifdef BIAS_CTRL_AUTO_RETRY_EN
            retryCnt     <= '0;
`endif
        end else begin
            state        <= stateNext;
            cnt          <= cntNext;
            EN_IBIAS_O   <= enIbiasNext;
            EN_VBIAS_O   <= enVbiasNext;
            BG_STARTUP_O <= startupNext;
            TRIM_IBIAS_O <= trimIbiasNext;
            TRIM_VBIAS_O <= trimVbiasNext;
            READY_O      <= readyNext;
            FAULT_O      <= faultNext;
`ifdef BIAS_CTRL_AUTO_RETRY_EN
            retryCnt     <= retryNext;
`endif
        end
    end

    always_comb begin
        stateNext     = state;
        cntNext       = cnt;
        enIbiasNext   = EN_IBIAS_O;
        enVbiasNext   = EN_VBIAS_O;
        startupNext   = BG_STARTUP_O;
        trimIbiasNext = TRIM_IBIAS_O;
        trimVbiasNext = TRIM_VBIAS_O;
        readyNext     = READY_O;
        faultNext     = FAULT_O;
`ifdef BIAS_CTRL_AUTO_RETRY_EN
        retryNext     = retryCnt;
`endif

        case (state)
            IDLE: begin
                enIbiasNext   = 1'b0;
                enVbiasNext   = 1'b0;
                startupNext   = 1'b0;
                readyNext     = 1'b0;
                faultNext     = 1'b0;
                trimIbiasNext = TRIM_IBIAS_CFG_I;
                trimVbiasNext = TRIM_VBIAS_CFG_I;
`ifdef BIAS_CTRL_AUTO_RETRY_EN
                retryNext     = '0;
`endif
                if (reqAny) begin
                    enIbiasNext = REQ_IBIAS_I;
                    enVbiasNext = REQ_VBIAS_I;
                    startupNext = 1'b1;
                    cntNext     = STARTUP_LOAD;
                    stateNext   = STARTUP;
                end
            end
            STARTUP: begin
                if (cnt == '0) begin
                    startupNext = 1'b0;
                    cntNext     = SETTLE_LOAD;
                    stateNext   = SETTLE;
                end else begin
                    cntNext = cnt - 1'b1;
                end
            end
            SETTLE: begin
                // A valid flag arriving on the last count still wins over timeout.
                if (vsync) begin
                    readyNext = 1'b1;
                    stateNext = ON;
`ifdef BIAS_CTRL_AUTO_RETRY_EN
                    retryNext = '0;
`endif
                end else if (cnt == '0) begin
`ifdef BIAS_CTRL_AUTO_RETRY_EN
                    if (retryCnt != 2'd3) begin
                        retryNext   = retryCnt + 2'd1;
                        startupNext = 1'b1;
                        cntNext     = STARTUP_LOAD;
                        stateNext   = STARTUP;
                    end else begin
                        enIbiasNext = 1'b0;
                        enVbiasNext = 1'b0;
                        startupNext = 1'b0;
                        readyNext   = 1'b0;
                        faultNext   = 1'b1;
                        stateNext   = FAULT;
                    end
`else
                    enIbiasNext = 1'b0;
                    enVbiasNext = 1'b0;
                    startupNext = 1'b0;
                    readyNext   = 1'b0;
                    faultNext   = 1'b1;
                    stateNext   = FAULT;
`endif
                end else begin
                    cntNext = cnt - 1'b1;
                end
            end
            ON: begin
                trimIbiasNext = TRIM_IBIAS_CFG_I;
                trimVbiasNext = TRIM_VBIAS_CFG_I;
                if (!vsync) begin
                    enIbiasNext = 1'b0;
                    enVbiasNext = 1'b0;
                    readyNext   = 1'b0;
                    faultNext   = 1'b1;
                    stateNext   = FAULT;
                end else begin
                    enIbiasNext = REQ_IBIAS_I;
                    enVbiasNext = REQ_VBIAS_I;
                end
            end
            FAULT: begin
                enIbiasNext = 1'b0;
                enVbiasNext = 1'b0;
                startupNext = 1'b0;
                readyNext   = 1'b0;
                faultNext   = 1'b1;
                if (CLR_FAULT_I) begin
                    faultNext = 1'b0;
                    stateNext = IDLE;
                end
            end
            default: begin
                enIbiasNext   = 1'b0;
                enVbiasNext   = 1'b0;
                startupNext   = 1'b0;
                trimIbiasNext = '0;
                trimVbiasNext = '0;
                readyNext     = 1'b0;
                faultNext     = 1'b0;
                cntNext       = '0;
                stateNext     = IDLE;
            end
        endcase

        // Dropping every request abandons the sequence outright, whatever else happened.
        if ((state == STARTUP || state == SETTLE || state == ON) && !reqAny) begin
            enIbiasNext   = 1'b0;
            enVbiasNext   = 1'b0;
            startupNext   = 1'b0;
            trimIbiasNext = '0;
            trimVbiasNext = '0;
            readyNext     = 1'b0;
            faultNext     = 1'b0;
            cntNext       = '0;
            stateNext     = IDLE;
        end
    end

endmodule
